time_keeper: RTL and testbench
==============================

// Module: time_keeper
// PURPOSE
//  Parametrised hh:mm:ss time-of-day counter for the wall-clock datapath.
//  - Derives its own 1 Hz tick from the system clock.
//  - Supports run, stop and set modes, with per-field up/down stepping.
//  - Presents 24 h or 12 h (with PM flag) hours to the number-conversion
//    and display stages.
//  - Also produces a set-mode blink strobe for the LED/UI logic.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock cycles per second; prescaler terminal count = CLK_HZ-1
//  HOUR_MODE  24          24: hour out 0..23, pm=0; 12: hour out 1..12, pm valid
//  BLINK_DIV  4           blink toggles every CLK_HZ/BLINK_DIV cycles (default 2 Hz blink)
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  rstN     in   1   asynchronous active-low reset
//  on       in   1   1 = timekeeping enabled; 0 = STOP (time frozen, prescaler held at 0)
//  set      in   1   1 = SET mode (time frozen, stepping allowed)
//  sethms   in   2   field select in SET: 0 = sec, 1 = min, 2 = hour, 3 = none
//  upDown   in   1   step direction: 1 = increment, 0 = decrement
//  step     in   1   step request; edge-detected internally, one step per rising edge
//  hour     out  5   hours, format per HOUR_MODE
//  min      out  6   minutes 0..59
//  sec      out  6   seconds 0..59
//  pm       out  1   12 h mode: 1 when internal hour >= 12; 0 in 24 h mode
//  secTick  out  1   one-cycle pulse when sec advances in RUN
//  blink    out  1   square wave in SET (starts 1 on SET entry); 0 outside SET
// BEHAVIOUR
//  - Reset (rstN=0, async):
//    - hour/min/sec internal = 0, prescaler = 0, blink = 0, secTick = 0, step history = 0.
//    - Outputs: 24 h mode hour=0; 12 h mode hour=12, pm=0.
//  - Modes (registered state), evaluated every cycle; priority STOP > SET > RUN:
//    - STOP: on=0.
//    - SET:  on=1, set=1.
//    - RUN:  on=1, set=0.
//  - RUN:
//    - Prescaler counts 0..CLK_HZ-1.
//    - At terminal count: prescaler wraps to 0, secTick=1 for that cycle, time advances by 1 s.
//    - Carry chain in the same cycle: sec 59->0 carries to min; min 59->0 carries to hour;
//      hour 23->0. 23:59:59 -> 00:00:00.
//    - Outputs update the cycle after the terminal count (registered); secTick aligned with the new sec.
//  - SET:
//    - Prescaler held at 0; no ticks.
//    - stepEdge = step & ~stepQ, where stepQ is step registered.
//    - On stepEdge, the selected field steps by +/-1 with wrap, no carry into other fields:
//      - sec/min 59<->0;
//      - hour 23<->0 (internal representation, regardless of HOUR_MODE).
//    - sethms=3: step ignored.
//    - Result visible one cycle after the edge.
//    - step held high produces exactly one step.
//  - SET -> RUN: prescaler restarts from 0, so the first tick comes CLK_HZ cycles after exit.
//    sec is not cleared.
//  - STOP: all time registers hold; prescaler = 0; step ignored; secTick = 0.
//  - blink:
//    - On SET entry: counter cleared, blink=1.
//    - In SET: toggles every CLK_HZ/BLINK_DIV cycles.
//    - Leaving SET: forced 0 the next cycle.
//  - 12 h mapping (combinational from internal hour h):
//    - h=0 -> 12;
//    - 1..12 -> h;
//    - 13..23 -> h-12;
//    - pm = (h >= 12).
//  - Widths: prescaler $clog2(CLK_HZ) bits. Comparisons are exact-equality on terminal values;
//    no out-of-range state is reachable.
//  - set and on changing in the same cycle as a terminal count: the mode sampled that cycle
//    decides, and a tick is taken only if the mode is RUN.
//  - Reset asserted mid-step or mid-tick: all state cleared immediately; no partial update survives.
// TESTING (CLK_HZ=4, BLINK_DIV=2 unless noted)
//  1. Release rstN, on=1, set=0.
//     -> secTick every 4th cycle, first tick 4 cycles after release; sec 0,1,2...
//  2. Preload 23:59:58 via SET, then RUN.
//     -> after 2 ticks 00:00:00; min and hour wrap in the same cycle as sec.
//  3. SET, sethms=1, upDown=0, min=0, single step pulse -> min=59, hour unchanged.
//     step held 10 cycles -> exactly one step.
//  4. HOUR_MODE=12, internal hour stepped 11->12->13->0 in SET.
//     -> hour/pm = 11/0, 12/1, 1/1, 12/0.
//  5. RUN with prescaler at 2, set=1 for 3 cycles then 0.
//     -> no tick during SET; first tick 4 cycles after set falls; blink 1,1,0 pattern while set.
//  6. on=0 mid-count, then rstN pulse while on=0.
//     -> time frozen, secTick=0; reset clears to 00:00:00, blink=0.

Source files
------------

// File: rtl/time_keeper.sv
// time_keeper: hh:mm:ss time-of-day counter with a self-derived 1 Hz tick,
// run/stop/set modes, per-field stepping, 12/24 h presentation and a set-mode blink strobe.
module time_keeper #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int HOUR_MODE = 24,
    parameter int BLINK_DIV = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       on,
    input  logic       set,
    input  logic [1:0] sethms,
    input  logic       upDown,
    input  logic       step,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       pm,
    output logic       secTick,
    output logic       blink
);

    localparam int PW            = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BLINK_CYC_RAW = CLK_HZ / BLINK_DIV;
    localparam int BLINK_CYC     = (BLINK_CYC_RAW > 0) ? BLINK_CYC_RAW : 1;
    localparam int BW            = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    localparam bit IS_12H = (HOUR_MODE == 12);

    typedef enum logic [1:0] {
        MODE_STOP,
        MODE_SET,
        MODE_RUN
    } mode_t;

    mode_t           w_mode;
    mode_t           r_mode;
    logic [PW-1:0]   r_presc;
    logic            r_secTick;
    logic [5:0]      r_sec;
    logic [5:0]      r_min;
    logic [4:0]      r_hour;
    logic            r_stepQ;
    logic [BW-1:0]   r_blinkCnt;
    logic            r_blink;
    logic            w_tick;
    logic            w_stepEdge;
    logic [5:0]      w_secStep;
    logic [5:0]      w_minStep;
    logic [4:0]      w_hourStep;
    logic [5:0]      w_secInc;
    logic [5:0]      w_minInc;
    logic [4:0]      w_hourInc;
    logic [4:0]      w_hour12;

    // Wrapping +/-1 on a field whose legal range is 0..last.
    function automatic logic [5:0] stepWrap(input logic [5:0] value,
                                            input logic [5:0] last,
                                            input logic       up);
        if (up) begin
            return (value == last) ? 6'd0 : value + 6'd1;
        end
        return (value == 6'd0) ? last : value - 6'd1;
    endfunction

    always_comb begin
        if (!on) begin
            w_mode = MODE_STOP;
        end else if (set) begin
            w_mode = MODE_SET;
        end else begin
            w_mode = MODE_RUN;
        end
    end

    assign w_tick     = (w_mode == MODE_RUN) && (r_presc == PRESC_LAST);
    assign w_stepEdge = step & ~r_stepQ;

    assign w_secStep  = stepWrap(r_sec, 6'd59, upDown);
    assign w_minStep  = stepWrap(r_min, 6'd59, upDown);
    assign w_hourStep = 5'(stepWrap({1'b0, r_hour}, 6'd23, upDown));
    assign w_secInc   = stepWrap(r_sec, 6'd59, 1'b1);
    assign w_minInc   = stepWrap(r_min, 6'd59, 1'b1);
    assign w_hourInc  = 5'(stepWrap({1'b0, r_hour}, 6'd23, 1'b1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_presc   <= '0;
            r_secTick <= 1'b0;
        end else if (w_mode == MODE_RUN) begin
            if (w_tick) begin
                r_presc   <= '0;
                r_secTick <= 1'b1;
            end else begin
                r_presc   <= r_presc + PW'(1);
                r_secTick <= 1'b0;
            end
        end else begin
            r_presc   <= '0;
            r_secTick <= 1'b0;
        end
    end

    // A tick ripples through the whole carry chain in one cycle; stepping touches only its own field.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= '0;
        end else if (w_tick) begin
            r_sec <= w_secInc;
            if (r_sec == 6'd59) begin
                r_min <= w_minInc;
                if (r_min == 6'd59) begin
                    r_hour <= w_hourInc;
                end
            end
        end else if ((w_mode == MODE_SET) && w_stepEdge) begin
            case (sethms)
                2'd0:    r_sec  <= w_secStep;
                2'd1:    r_min  <= w_minStep;
                2'd2:    r_hour <= w_hourStep;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_stepQ <= 1'b0;
            r_mode  <= MODE_STOP;
        end else begin
            r_stepQ <= step;
            r_mode  <= w_mode;
        end
    end

    // Blink restarts high on every SET entry so the UI always shows the field immediately.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_blinkCnt <= '0;
            r_blink    <= 1'b0;
        end else if (w_mode == MODE_SET) begin
            if (r_mode != MODE_SET) begin
                r_blinkCnt <= '0;
                r_blink    <= 1'b1;
            end else if (r_blinkCnt == BLINK_LAST) begin
                r_blinkCnt <= '0;
                r_blink    <= ~r_blink;
            end else begin
                r_blinkCnt <= r_blinkCnt + BW'(1);
            end
        end else begin
            r_blinkCnt <= '0;
            r_blink    <= 1'b0;
        end
    end

    always_comb begin
        w_hour12 = r_hour;
        if (r_hour == 5'd0) begin
            w_hour12 = 5'd12;
        end else if (r_hour > 5'd12) begin
            w_hour12 = r_hour - 5'd12;
        end
    end

    assign hour    = IS_12H ? w_hour12 : r_hour;
    assign pm      = IS_12H && (r_hour >= 5'd12);
    assign min     = r_min;
    assign sec     = r_sec;
    assign secTick = r_secTick;
    assign blink   = r_blink;

endmodule

// File: tb/tb_time_keeper.sv
// Testbench for time_keeper: directed scenarios plus randomized stimulus, all checked
// against a seconds-of-day reference model; a 24 h and a 12 h instance share the inputs.
module tb_time_keeper;

    localparam int CLK_HZ    = 4;
    localparam int BLINK_DIV = 2;
    localparam int BLINK_CYC = CLK_HZ / BLINK_DIV;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic       on = 1'b0;
    logic       set = 1'b0;
    logic [1:0] sethms = 2'd3;
    logic       upDown = 1'b0;
    logic       step = 1'b0;

    logic [4:0] hour24, hour12;
    logic [5:0] min24, min12, sec24, sec12;
    logic       pm24, pm12, tick24, tick12, blink24, blink12;

    int checks = 0;
    int failures = 0;

    int tod = 0;
    int runCount = 0;
    int setCount = 0;
    bit mTick = 1'b0;
    bit prevStep = 1'b0;

    logic [39:0] obsVec;
    assign obsVec = {hour24, min24, sec24, tick24, blink24, pm24,
                     hour12, pm12, min12, sec12, tick12, blink12};

    time_keeper #(.CLK_HZ(CLK_HZ), .HOUR_MODE(24), .BLINK_DIV(BLINK_DIV)) u_dut24 (
        .clk(clk), .rstN(rstN), .on(on), .set(set), .sethms(sethms), .upDown(upDown),
        .step(step), .hour(hour24), .min(min24), .sec(sec24), .pm(pm24),
        .secTick(tick24), .blink(blink24)
    );

    time_keeper #(.CLK_HZ(CLK_HZ), .HOUR_MODE(12), .BLINK_DIV(BLINK_DIV)) u_dut12 (
        .clk(clk), .rstN(rstN), .on(on), .set(set), .sethms(sethms), .upDown(upDown),
        .step(step), .hour(hour12), .min(min12), .sec(sec12), .pm(pm12),
        .secTick(tick12), .blink(blink12)
    );

    always #5 clk = ~clk;

    // Reference model: time is one integer of seconds since midnight.
    function automatic void modelReset();
        tod      = 0;
        runCount = 0;
        setCount = 0;
        mTick    = 1'b0;
        prevStep = 1'b0;
    endfunction

    function automatic void modelEdge();
        int h, m, s;
        mTick = 1'b0;
        if (on && !set) begin
            runCount++;
            setCount = 0;
            if (runCount == CLK_HZ) begin
                runCount = 0;
                mTick    = 1'b1;
                tod      = (tod + 1) % 86400;
            end
        end else if (on && set) begin
            runCount = 0;
            setCount++;
            if (step && !prevStep && sethms != 2'd3) begin
                h = tod / 3600;
                m = (tod / 60) % 60;
                s = tod % 60;
                case (sethms)
                    2'd0:    s = (s + (upDown ? 1 : 59)) % 60;
                    2'd1:    m = (m + (upDown ? 1 : 59)) % 60;
                    default: h = (h + (upDown ? 1 : 23)) % 24;
                endcase
                tod = h * 3600 + m * 60 + s;
            end
        end else begin
            runCount = 0;
            setCount = 0;
        end
        prevStep = step;
    endfunction

    function automatic logic [39:0] expVec();
        int h, m, s, h12;
        logic bl;
        h   = tod / 3600;
        m   = (tod / 60) % 60;
        s   = tod % 60;
        h12 = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        bl  = (setCount > 0) && ((((setCount - 1) / BLINK_CYC) % 2) == 0);
        return {5'(h), 6'(m), 6'(s), mTick, bl, 1'b0,
                5'(h12), 1'(h >= 12), 6'(m), 6'(s), mTick, bl};
    endfunction

    task automatic runCycle();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic doStep(input logic [1:0] field, input logic dir);
        sethms = field;
        upDown = dir;
        step   = 1'b1;
        runCycle();
        step   = 1'b0;
        runCycle();
    endtask

    task automatic test_reset();
        #2 rstN = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        if (obsVec !== expVec()) begin
            failures++;
            $display("[TB] FAIL reset_vector: dut=%h model=%h", obsVec, expVec());
        end
        checks++;
        if ({hour24, hour12, pm12, blink24, tick24} !== {5'd0, 5'd12, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_values: hour24=%0d hour12=%0d pm=%b blink=%b tick=%b, required 0/12/0/0/0",
                     hour24, hour12, pm12, blink24, tick24);
        end
        checks++;
        rstN = 1'b1;
    endtask

    task automatic test_run_ticks();
        on  = 1'b1;
        set = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            runCycle();
            if (obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL run_ticks cycle %0d: dut=%h model=%h", i, obsVec, expVec());
            end
            checks++;
            if ({tick24, sec24} !== {(i % 4) == 0, 6'(i / 4)}) begin
                failures++;
                $display("[TB] FAIL run_ticks_const cycle %0d: tick=%b sec=%0d, required tick=%b sec=%0d",
                         i, tick24, sec24, (i % 4) == 0, i / 4);
            end
            checks++;
        end
    endtask

    task automatic test_rollover();
        int guard;
        set   = 1'b1;
        guard = 0;
        while ((tod % 60) != 58 && guard < 70) begin
            doStep(2'd0, 1'b0);
            guard++;
        end
        doStep(2'd1, 1'b0);
        doStep(2'd2, 1'b0);
        if ({hour24, min24, sec24} !== {5'd23, 6'd59, 6'd58}) begin
            failures++;
            $display("[TB] FAIL preload: got %0d:%0d:%0d, required 23:59:58", hour24, min24, sec24);
        end
        checks++;
        set = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            runCycle();
            if (obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL rollover cycle %0d: dut=%h model=%h", i, obsVec, expVec());
            end
            checks++;
            if (i == 4 && {hour24, min24, sec24, tick24} !== {5'd23, 6'd59, 6'd59, 1'b1}) begin
                failures++;
                $display("[TB] FAIL rollover_59: got %0d:%0d:%0d tick=%b, required 23:59:59 tick=1",
                         hour24, min24, sec24, tick24);
            end
            if (i == 8 && {hour24, min24, sec24, tick24, hour12, pm12} !==
                          {5'd0, 6'd0, 6'd0, 1'b1, 5'd12, 1'b0}) begin
                failures++;
                $display("[TB] FAIL rollover_wrap: got %0d:%0d:%0d tick=%b h12=%0d pm=%b, required 0:0:0 tick=1 h12=12 pm=0",
                         hour24, min24, sec24, tick24, hour12, pm12);
            end
            if (i == 4 || i == 8) checks++;
        end
    endtask

    task automatic test_set_step();
        set    = 1'b1;
        sethms = 2'd1;
        upDown = 1'b0;
        step   = 1'b0;
        runCycle();
        if (min24 !== 6'd0) begin
            failures++;
            $display("[TB] FAIL set_step_pre: min=%0d, required 0", min24);
        end
        checks++;
        step = 1'b1;
        runCycle();
        if ({min24, hour24} !== {6'd59, 5'd0} || obsVec !== expVec()) begin
            failures++;
            $display("[TB] FAIL set_step_down: min=%0d hour=%0d, required min=59 hour=0", min24, hour24);
        end
        checks++;
        step = 1'b0;
        runCycle();
        upDown = 1'b1;
        step   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            runCycle();
            if (obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL step_held cycle %0d: dut=%h model=%h", i, obsVec, expVec());
            end
            checks++;
        end
        if (min24 !== 6'd0) begin
            failures++;
            $display("[TB] FAIL step_held_once: min=%0d, required 0", min24);
        end
        checks++;
        step = 1'b0;
        runCycle();
    endtask

    task automatic test_hour12();
        int guard;
        logic [5:0] want [4];
        want[0] = {5'd11, 1'b0};
        want[1] = {5'd12, 1'b1};
        want[2] = {5'd1, 1'b1};
        want[3] = {5'd12, 1'b0};
        set   = 1'b1;
        guard = 0;
        while ((tod / 3600) != 11 && guard < 30) begin
            doStep(2'd2, 1'b1);
            guard++;
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 1 || k == 2) begin
                doStep(2'd2, 1'b1);
            end else if (k == 3) begin
                guard = 0;
                while ((tod / 3600) != 0 && guard < 30) begin
                    doStep(2'd2, 1'b1);
                    guard++;
                end
            end
            if ({hour12, pm12} !== want[k] || obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL hour12 step %0d: hour=%0d pm=%b, required hour=%0d pm=%b",
                         k, hour12, pm12, want[k][5:1], want[k][0]);
            end
            checks++;
        end
    endtask

    task automatic test_set_exit();
        logic [2:0] blinkWant;
        blinkWant = 3'b110;
        set = 1'b0;
        runCycle();
        runCycle();
        set = 1'b1;
        for (int i = 0; i < 3; i++) begin
            runCycle();
            if ({blink24, tick24} !== {blinkWant[2 - i], 1'b0} || obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL set_blink cycle %0d: blink=%b tick=%b, required blink=%b tick=0",
                         i, blink24, tick24, blinkWant[2 - i]);
            end
            checks++;
        end
        set = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            runCycle();
            if ({tick24, blink24} !== {i == 4, 1'b0} || obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL set_exit cycle %0d: tick=%b blink=%b, required tick=%b blink=0",
                         i, tick24, blink24, i == 4);
            end
            checks++;
        end
    endtask

    task automatic test_stop_reset();
        int frozenSec;
        set = 1'b0;
        on  = 1'b1;
        runCycle();
        runCycle();
        frozenSec = tod % 60;
        on     = 1'b0;
        sethms = 2'd0;
        upDown = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step = (i == 2);
            runCycle();
            if ({tick24, sec24} !== {1'b0, 6'(frozenSec)} || obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL stop_frozen cycle %0d: tick=%b sec=%0d, required tick=0 sec=%0d",
                         i, tick24, sec24, frozenSec);
            end
            checks++;
        end
        #2 rstN = 1'b0;
        #1;
        modelReset();
        if ({hour24, min24, sec24, blink24, hour12} !== {5'd0, 6'd0, 6'd0, 1'b0, 5'd12}) begin
            failures++;
            $display("[TB] FAIL stop_reset: got %0d:%0d:%0d blink=%b h12=%0d, required 0:0:0 blink=0 h12=12",
                     hour24, min24, sec24, blink24, hour12);
        end
        checks++;
        @(posedge clk);
        #1 rstN = 1'b1;
        on     = 1'b1;
        set    = 1'b1;
        runCycle();
        step = 1'b1;
        runCycle();
        if ({sec24, blink24} !== {6'd1, 1'b1} || obsVec !== expVec()) begin
            failures++;
            $display("[TB] FAIL set_before_reset: sec=%0d blink=%b, required sec=1 blink=1", sec24, blink24);
        end
        checks++;
        #2 rstN = 1'b0;
        #1;
        modelReset();
        if ({sec24, blink24, tick24} !== {6'd0, 1'b0, 1'b0} || obsVec !== expVec()) begin
            failures++;
            $display("[TB] FAIL reset_mid_set: sec=%0d blink=%b tick=%b, required 0/0/0", sec24, blink24, tick24);
        end
        checks++;
        @(posedge clk);
        #1 rstN = 1'b1;
        set  = 1'b0;
        step = 1'b0;
    endtask

    task automatic test_random();
        on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (on ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0)) on = ~on;
            if ($urandom_range(0, 11) == 0) set = ~set;
            sethms = 2'($urandom_range(0, 3));
            upDown = 1'($urandom_range(0, 1));
            step   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rstN = 1'b0;
                #1;
                modelReset();
                if (obsVec !== expVec()) begin
                    failures++;
                    $display("[TB] FAIL random_reset iter %0d: dut=%h model=%h", i, obsVec, expVec());
                end
                checks++;
                rstN = 1'b1;
            end
            runCycle();
            if (obsVec !== expVec()) begin
                failures++;
                $display("[TB] FAIL random iter %0d: dut=%h model=%h", i, obsVec, expVec());
            end
            checks++;
        end
    endtask

    initial begin
        $display("[TB] time_keeper bench start");
        test_reset();
        test_run_ticks();
        test_rollover();
        test_set_step();
        test_hour12();
        test_set_exit();
        test_stop_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
